// File: rtl/eim_host_master_pkg.sv
// eim_host_master_pkg: shared widths, FSM state encoding and default phase lengths for the EIM host master.
package eim_host_master_pkg;
    localparam int EIM_DA_W = 8;
    localparam int unsigned DEF_ADDR_CYCLES = 4;
    localparam int unsigned DEF_DATA_CYCLES = 4;
    localparam int unsigned DEF_HOLD_CYCLES = 3;
    localparam int unsigned DEF_TURN_CYCLES = 2;
    localparam int unsigned DEF_IDLE_CYCLES = 2;
    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_WDATA, ST_WHOLD, ST_TURN, ST_RDATA, ST_RECOVER
    } state_t;
    function automatic logic [7:0] phase_load(int unsigned n);
        return 8'(n - 1);
    endfunction
endpackage

// File: rtl/eim_host_master_phase_timer.sv
// eim_host_master_phase_timer: loadable 8-bit down-counter that parks at zero and flags it.
module eim_host_master_phase_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       zero
);
    logic [7:0] cnt;
    assign zero = cnt == 8'd0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else        cnt <= load ? load_val : zero ? cnt : cnt - 8'd1;
endmodule

// File: rtl/eim_host_master.sv
// eim_host_master: single-beat EIM initiator; stretches every bus phase so a double-syncing responder samples cleanly.
module eim_host_master
    import eim_host_master_pkg::*;
#(
    parameter int unsigned ADDR_CYCLES = DEF_ADDR_CYCLES,
    parameter int unsigned DATA_CYCLES = DEF_DATA_CYCLES,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned TURN_CYCLES = DEF_TURN_CYCLES,
    parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [EIM_DA_W-1:0] req_addr,
    input  logic [EIM_DA_W-1:0] req_wdata,
    output logic                rsp_valid,
    output logic [EIM_DA_W-1:0] rsp_rdata,
    output logic                eim_cs0_n,
    output logic                eim_lba_n,
    output logic                eim_wr_n,
    output logic                eim_oe_n,
    output logic [EIM_DA_W-1:0] eim_da_out,
    output logic                eim_da_oe,
    input  logic [EIM_DA_W-1:0] eim_da_in
);
    state_t state, nxt;
    logic accept, zero, load, wr_q;
    logic [7:0] load_val;
    logic [EIM_DA_W-1:0] addr_q, wdata_q, a_eff, sync1, sync2;

    assign req_ready = state == ST_IDLE;
    assign accept    = req_valid & req_ready;
    assign a_eff     = accept ? req_addr : addr_q;

    eim_host_master_phase_timer u_timer (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .zero(zero)
    );

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:    nxt = accept ? ST_ADDR : ST_IDLE;
            ST_ADDR:    nxt = zero ? (wr_q ? ST_WDATA : ST_TURN) : ST_ADDR;
            ST_WDATA:   nxt = zero ? ST_WHOLD : ST_WDATA;
            ST_WHOLD:   nxt = zero ? ST_RECOVER : ST_WHOLD;
            ST_TURN:    nxt = zero ? ST_RDATA : ST_TURN;
            ST_RDATA:   nxt = zero ? ST_RECOVER : ST_RDATA;
            ST_RECOVER: nxt = zero ? ST_IDLE : ST_RECOVER;
            default:    nxt = ST_IDLE;
        endcase
        load     = nxt != state;
        load_val = nxt == ST_ADDR    ? phase_load(ADDR_CYCLES) :
                   nxt == ST_TURN    ? phase_load(TURN_CYCLES) :
                   nxt == ST_WHOLD   ? phase_load(HOLD_CYCLES) :
                   nxt == ST_RECOVER ? phase_load(IDLE_CYCLES) :
                   nxt inside {ST_WDATA, ST_RDATA} ? phase_load(DATA_CYCLES) : 8'd0;
    end

    // Pins are registered from the next state so each level covers exactly its state's cycles.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= ST_IDLE;
            eim_cs0_n  <= 1'b1;
            eim_lba_n  <= 1'b1;
            eim_wr_n   <= 1'b1;
            eim_oe_n   <= 1'b1;
            eim_da_oe  <= 1'b0;
            eim_da_out <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sync1      <= '0;
            sync2      <= '0;
        end else begin
            state      <= nxt;
            eim_cs0_n  <= nxt inside {ST_IDLE, ST_RECOVER};
            eim_lba_n  <= nxt != ST_ADDR;
            eim_wr_n   <= nxt != ST_WDATA;
            eim_oe_n   <= nxt != ST_RDATA;
            eim_da_oe  <= nxt inside {ST_ADDR, ST_WDATA, ST_WHOLD};
            eim_da_out <= nxt == ST_ADDR ? a_eff : nxt == ST_WDATA ? wdata_q : eim_da_out;
            rsp_valid  <= nxt == ST_RECOVER && state != ST_RECOVER;
            sync1      <= eim_da_in;
            sync2      <= sync1;
            if (state == ST_RDATA && zero) rsp_rdata <= sync2;
            if (accept) {wr_q, addr_q, wdata_q} <= {req_write, req_addr, req_wdata};
        end
endmodule

// File: tb/tb_eim_host_master.sv
// tb_eim_host_master: two masters (default and stretched-data timing) each wired to a responder model; scoreboard checks responses.
module tb_eim_host_master;
    typedef struct {
        logic [7:0] rd;
        int         t;
        int         lat;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] req_valid = '0, req_write = '0;
    logic [1:0][7:0] req_addr = '0, req_wdata = '0;
    logic [1:0] req_ready, rsp_valid, cs0_n, lba_n, wr_n, oe_n, da_oe;
    logic [1:0][7:0] rsp_rdata, da_out, da_in;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_err = 0;
    int hi_run [2] = '{0, 0};
    int idle_min [2] = '{2, 1};
    logic [7:0] last_rd [2] = '{8'h00, 8'h00};
    exp_t sb [2][$];

    eim_host_master u0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .eim_cs0_n(cs0_n[0]), .eim_lba_n(lba_n[0]), .eim_wr_n(wr_n[0]), .eim_oe_n(oe_n[0]),
        .eim_da_out(da_out[0]), .eim_da_oe(da_oe[0]), .eim_da_in(da_in[0])
    );

    eim_host_master #(
        .ADDR_CYCLES(1), .DATA_CYCLES(6), .HOLD_CYCLES(1), .TURN_CYCLES(1), .IDLE_CYCLES(1)
    ) u1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .eim_cs0_n(cs0_n[1]), .eim_lba_n(lba_n[1]), .eim_wr_n(wr_n[1]), .eim_oe_n(oe_n[1]),
        .eim_da_out(da_out[1]), .eim_da_oe(da_oe[1]), .eim_da_in(da_in[1])
    );

    // Responder: double-syncs pins and DA. With 4 data cycles the master samples DA three cycles
    // after oe_n falls, so u0's responder answers one cycle after oe_n; u1's uses the full 3-cycle path.
    for (genvar g = 0; g < 2; g++) begin : g_rsp
        logic [7:0] mem [256];
        logic [3:0] p1 = 4'hF, p2 = 4'hF;
        logic [7:0] d1, d2, a, rd;
        logic drv = 1'b0;
        always @(posedge clk) begin
            p1  <= {cs0_n[g], lba_n[g], wr_n[g], oe_n[g]};
            p2  <= p1;
            d1  <= da_in[g];
            d2  <= d1;
            if (!p2[3] && !p2[2]) a <= d2;
            if (!p2[3] && !p2[1]) mem[a] <= d2;
            drv <= (g == 0) ? !oe_n[g] : (!p2[3] && !p2[0]);
            rd  <= mem[a];
        end
        assign da_in[g] = da_oe[g] ? da_out[g] : drv ? rd : 8'h00;
    end

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("wr_oe_both_low[%0d]", i), int'(!wr_n[i] && !oe_n[i]), 0);
                chk($sformatf("da_oe_while_oe_low[%0d]", i), int'(!oe_n[i] && da_oe[i]), 0);
                if (cs0_n[i]) hi_run[i]++;
                else begin
                    if (hi_run[i] != 0)
                        chk($sformatf("cs_idle_min[%0d]", i),
                            hi_run[i] < idle_min[i] ? hi_run[i] : idle_min[i], idle_min[i]);
                    hi_run[i] = 0;
                end
                if (rsp_valid[i]) begin
                    chk($sformatf("rsp_expected[%0d]", i), int'(sb[i].size() > 0), 1);
                    if (sb[i].size() > 0) begin
                        e = sb[i].pop_front();
                        chk($sformatf("rsp_latency[%0d]", i), cyc - e.t, e.lat);
                        chk($sformatf("rsp_rdata[%0d]", i), int'(rsp_rdata[i]), int'(e.rd));
                    end
                end
            end
        end
    endtask

    task automatic issue(int i, bit wr, logic [7:0] a, logic [7:0] d, logic [7:0] e_rd, int lat, bit hold);
        int n = 0;
        @(negedge clk);
        req_write[i] = wr;
        req_addr[i]  = a;
        req_wdata[i] = d;
        req_valid[i] = 1'b1;
        while (!req_ready[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", int'(n >= 50), 0);
        @(posedge clk);
        #1;
        sb[i].push_back(exp_t'{wr ? last_rd[i] : e_rd, cyc, lat});
        if (!wr) last_rd[i] = e_rd;
        if (!hold) req_valid[i] = 1'b0;
    endtask

    task automatic txn(int i, bit wr, logic [7:0] a, logic [7:0] d, logic [7:0] e_rd, int lat, int busy, bit hold = 0);
        int k = 0;
        issue(i, wr, a, d, e_rd, lat, hold);
        while (k < 100) begin
            @(negedge clk);
            if (req_ready[i]) break;
            k++;
            if (k == lat) req_valid[i] = 1'b0;
        end
        chk($sformatf("busy_cycles[%0d]", i), k, busy);
    endtask

    task automatic wr0(logic [7:0] a, logic [7:0] d); txn(0, 1, a, d, 8'h00, 11, 13); endtask
    task automatic rd0(logic [7:0] a, logic [7:0] e); txn(0, 0, a, 8'h00, e, 10, 12); endtask
    task automatic wr1(logic [7:0] a, logic [7:0] d); txn(1, 1, a, d, 8'h00, 8, 9); endtask
    task automatic rd1(logic [7:0] a, logic [7:0] e); txn(1, 0, a, 8'h00, e, 8, 9); endtask

    initial begin
        int n;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_strobes", int'({cs0_n[i], lba_n[i], wr_n[i], oe_n[i]}), 4'hF);
            chk("rst_da_oe", int'(da_oe[i]), 0);
            chk("rst_da_out", int'(da_out[i]), 0);
            chk("rst_rsp_valid", int'(rsp_valid[i]), 0);
            chk("rst_rsp_rdata", int'(rsp_rdata[i]), 0);
            chk("rst_req_ready", int'(req_ready[i]), 1);
        end
        rst_n = 1'b1;
        wr0(8'h00, 8'h05);
        rd0(8'h00, 8'h05);
        wr0(8'h07, 8'h3C);
        rd0(8'h07, 8'h3C);
        rd0(8'h00, 8'h05);
        txn(0, 1, 8'h10, 8'h77, 8'h00, 11, 13, 1);
        rd0(8'h10, 8'h77);
        issue(0, 0, 8'h07, 8'h00, 8'h3C, 10, 0);
        n = 0;
        while (oe_n[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("oe_fall_timeout", int'(n >= 50), 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cs0_n", int'(cs0_n[0]), 1);
        chk("mid_rst_oe_n", int'(oe_n[0]), 1);
        chk("mid_rst_da_oe", int'(da_oe[0]), 0);
        chk("mid_rst_rsp_valid", int'(rsp_valid[0]), 0);
        chk("mid_rst_rsp_rdata", int'(rsp_rdata[0]), 0);
        sb[0].delete();
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        rd0(8'h00, 8'h05);
        wr0(8'hFF, 8'hA5);
        rd0(8'hFF, 8'hA5);
        wr1(8'h12, 8'hC3);
        rd1(8'h12, 8'hC3);
        wr1(8'hFF, 8'h0F);
        rd1(8'hFF, 8'h0F);
        rd1(8'h12, 8'hC3);
        repeat (5) @(negedge clk);
        chk("sb_drained[0]", sb[0].size(), 0);
        chk("sb_drained[1]", sb[1].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
